// File: rtl/spi_frame_sequencer_pkg.sv
// Shared types and word-format constants for the SPI frame sequencer slice.
package spi_frame_sequencer_pkg;

  localparam int WORD_W = 16;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  // Bit 15 of each SPI word tells the receiver which axis it carries.
  localparam logic TAG_X = 1'b1;
  localparam logic TAG_Y = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    START_X,
    WAIT_X,
    GAP,
    START_Y,
    WAIT_Y,
    HOLDOFF
  } seq_state_t;

  // Word layouts produced by the packer that sits beside the sequencer.
  function automatic logic [WORD_W-1:0] make_x_word(input logic [X_W-1:0] x);
    return {TAG_X, {(WORD_W-1-X_W){1'b0}}, x};
  endfunction

  function automatic logic [WORD_W-1:0] make_y_word(input logic [Y_W-1:0] y);
    return {TAG_Y, {(WORD_W-1-Y_W){1'b0}}, y};
  endfunction

endpackage

// File: rtl/spi_frame_sequencer_if.sv
// Word-level handshake between the frame sequencer and the SPI shift engine.
interface spi_frame_sequencer_if;
  import spi_frame_sequencer_pkg::*;

  logic              spi_start;
  logic [WORD_W-1:0] spi_tx_data;
  logic              spi_busy;
  logic              spi_done;

  // Sequencer side: issues words and watches for completion.
  modport master (
    output spi_start,
    output spi_tx_data,
    input  spi_busy,
    input  spi_done
  );

  // Shift-engine side: accepts words and reports busy/done.
  modport slave (
    input  spi_start,
    input  spi_tx_data,
    output spi_busy,
    output spi_done
  );

endinterface

// File: rtl/spi_frame_sequencer_interval_timer.sv
// Loadable down-counter shared by the inter-word gap and the post-frame holdoff.
// It stops at zero; zero is asserted while the count sits at 0.
module spi_interval_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] value_d;
  logic [W-1:0] value_q;

  // Next count: a load wins, otherwise step down until zero is reached.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (value_q != '0) begin
      value_d = value_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign zero = (value_q == '0);

endmodule

// File: rtl/spi_frame_sequencer.sv
// Sequences one coordinate frame (X word, then Y word) to the SPI master.
// The newest coordinate lives in a shadow register that feeds the packer
// directly; coordinates arriving while a frame is in flight are coalesced.
module spi_frame_sequencer
  import spi_frame_sequencer_pkg::*;
#(
  parameter int GAP_CYCLES     = 8,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              coord_valid,
  input  logic [X_W-1:0]    coord_x,
  input  logic [Y_W-1:0]    coord_y,
  output logic [X_W-1:0]    pack_x,
  output logic [Y_W-1:0]    pack_y,
  output logic              pack_req,
  input  logic [WORD_W-1:0] xdata_tx,
  input  logic [WORD_W-1:0] ydata_tx,
  spi_frame_sequencer_if.master spi,
  output logic              frame_sent,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int TMR_MAX = (GAP_CYCLES > HOLDOFF_CYCLES) ? GAP_CYCLES : HOLDOFF_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);

  seq_state_t        state_d, state_q;
  logic [X_W-1:0]    pack_x_d, pack_x_q;
  logic [Y_W-1:0]    pack_y_d, pack_y_q;
  logic              pack_req_d, pack_req_q;
  logic              spi_start_d, spi_start_q;
  logic [WORD_W-1:0] spi_tx_data_d, spi_tx_data_q;
  logic              frame_sent_d, frame_sent_q;
  logic [CNT_W-1:0]  drop_count_d, drop_count_q;
  logic              pending_d, pending_q;

  logic              accept;
  logic              to_latch;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  spi_interval_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state, shadow capture, coalescing and handshake pulse decode.
  always_comb begin
    accept        = coord_valid & enable;
    state_d       = state_q;
    pack_x_d      = pack_x_q;
    pack_y_d      = pack_y_q;
    pack_req_d    = 1'b0;
    spi_start_d   = 1'b0;
    spi_tx_data_d = spi_tx_data_q;
    frame_sent_d  = 1'b0;
    drop_count_d  = drop_count_q;
    to_latch      = 1'b0;
    tmr_load      = 1'b0;
    tmr_val       = GAP_LOAD;

    case (state_q)
      IDLE: begin
        if (accept || pending_q) begin
          state_d  = LATCH;
          to_latch = 1'b1;
        end
      end
      LATCH: begin
        // Packer samples the shadow at the end of this cycle.
        state_d = START_X;
      end
      START_X: begin
        if (!spi.spi_busy) begin
          spi_tx_data_d = xdata_tx;
          spi_start_d   = 1'b1;
          state_d       = WAIT_X;
        end
      end
      WAIT_X: begin
        if (spi.spi_done) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          state_d = START_Y;
        end
      end
      START_Y: begin
        if (!spi.spi_busy) begin
          spi_tx_data_d = ydata_tx;
          spi_start_d   = 1'b1;
          state_d       = WAIT_Y;
        end
      end
      WAIT_Y: begin
        if (spi.spi_done) begin
          frame_sent_d = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = HOLD_LOAD;
          state_d      = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (tmr_zero) begin
          // A coordinate arriving on the last holdoff cycle is latched directly.
          if (pending_q || accept) begin
            state_d  = LATCH;
            to_latch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (to_latch) begin
      pack_req_d = 1'b1;
    end

    // Newest coordinate always wins; overwriting an unsent one is a drop.
    if (accept) begin
      pack_x_d = coord_x;
      pack_y_d = coord_y;
      if (pending_q) begin
        drop_count_d = sat_inc(drop_count_q);
      end
    end

    // Entering LATCH consumes whatever the shadow holds at that edge.
    if (to_latch) begin
      pending_d = 1'b0;
    end else if (accept) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pack_x_q      <= '0;
      pack_y_q      <= '0;
      pack_req_q    <= 1'b0;
      spi_start_q   <= 1'b0;
      spi_tx_data_q <= '0;
      frame_sent_q  <= 1'b0;
      drop_count_q  <= '0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pack_x_q      <= pack_x_d;
      pack_y_q      <= pack_y_d;
      pack_req_q    <= pack_req_d;
      spi_start_q   <= spi_start_d;
      spi_tx_data_q <= spi_tx_data_d;
      frame_sent_q  <= frame_sent_d;
      drop_count_q  <= drop_count_d;
      pending_q     <= pending_d;
    end
  end

  assign pack_x          = pack_x_q;
  assign pack_y          = pack_y_q;
  assign pack_req        = pack_req_q;
  assign spi.spi_start   = spi_start_q;
  assign spi.spi_tx_data = spi_tx_data_q;
  assign frame_sent      = frame_sent_q;
  assign drop_count      = drop_count_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer: a table of single-cycle vectors for
// capture/enable/latch behaviour plus hand sequences for multi-cycle cases.
module tb_spi_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        coord_valid = 1'b0;
  logic [9:0]  coord_x = '0;
  logic [8:0]  coord_y = '0;
  logic [9:0]  pack_x;
  logic [8:0]  pack_y;
  logic        pack_req;
  logic [15:0] xdata_tx = '0;
  logic [15:0] ydata_tx = '0;
  logic        frame_sent;
  logic [3:0]  drop_count;

  logic        busy_m = 1'b0;
  logic        done_m = 1'b0;
  logic        force_busy = 1'b0;
  int          spi_cnt = 0;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          n_frame = 0;
  int          done_cyc = 0;
  int          n_unstable = 0;
  int          st_cyc[$];
  int          st_dat[$];
  int          pr_cyc[$];
  int          fs_cyc[$];

  spi_frame_sequencer_if sif ();

  spi_frame_sequencer #(
    .GAP_CYCLES     (4),
    .HOLDOFF_CYCLES (10),
    .CNT_W          (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .coord_valid (coord_valid),
    .coord_x     (coord_x),
    .coord_y     (coord_y),
    .pack_x      (pack_x),
    .pack_y      (pack_y),
    .pack_req    (pack_req),
    .xdata_tx    (xdata_tx),
    .ydata_tx    (ydata_tx),
    .spi         (sif),
    .frame_sent  (frame_sent),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Packer: registers tagged words on the pack_req edge.
  always @(posedge clk) begin
    if (pack_req) begin
      xdata_tx <= {1'b1, 5'b0, pack_x};
      ydata_tx <= {1'b0, 6'b0, pack_y};
    end
  end

  // SPI master: busy for 20 cycles after start, done pulse on the 20th.
  always @(posedge clk) begin
    done_m <= 1'b0;
    if (reset) begin
      busy_m  <= 1'b0;
      spi_cnt <= 0;
    end else if (sif.spi_start && !busy_m) begin
      busy_m  <= 1'b1;
      spi_cnt <= 19;
    end else if (busy_m) begin
      if (spi_cnt == 1) done_m <= 1'b1;
      if (spi_cnt == 0) busy_m <= 1'b0;
      else spi_cnt <= spi_cnt - 1;
    end
  end

  assign sif.spi_busy = busy_m | force_busy;
  assign sif.spi_done = done_m;

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (sif.spi_start) begin
        st_cyc.push_back(cyc);
        st_dat.push_back(int'(sif.spi_tx_data));
      end
      if (pack_req) pr_cyc.push_back(cyc);
      if (frame_sent) begin
        n_frame++;
        fs_cyc.push_back(cyc);
      end
      if (sif.spi_done) done_cyc = cyc;
      if (busy_m && st_dat.size() > 0 && int'(sif.spi_tx_data) != st_dat[st_dat.size()-1])
        n_unstable++;
    end
  end

  function automatic int st_dat_at(input int i);
    if (i >= 0 && i < st_dat.size()) return st_dat[i];
    return -1;
  endfunction

  function automatic int st_cyc_at(input int i);
    if (i >= 0 && i < st_cyc.size()) return st_cyc[i];
    return -1000;
  endfunction

  function automatic int pr_cyc_at(input int i);
    if (i >= 0 && i < pr_cyc.size()) return pr_cyc[i];
    return -1000;
  endfunction

  function automatic int fs_cyc_at(input int i);
    if (i >= 0 && i < fs_cyc.size()) return fs_cyc[i];
    return -1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic pulse_coord(input logic [9:0] x, input logic [8:0] y);
    coord_valid = 1'b1;
    coord_x     = x;
    coord_y     = y;
    tick();
    coord_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string nm);
    int n = 0;
    while (n_frame < target && n < 500) begin
      tick();
      n++;
    end
    check(nm, n_frame, target);
  endtask

  task automatic wait_starts(input int target, input string nm);
    int n = 0;
    while (st_dat.size() < target && n < 200) begin
      tick();
      n++;
    end
    check(nm, st_dat.size(), target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pack_req"},   int'(pack_req), 0);
    check({tag, "_spi_start"},  int'(sif.spi_start), 0);
    check({tag, "_frame_sent"}, int'(frame_sent), 0);
    check({tag, "_drop"},       int'(drop_count), 0);
    check({tag, "_pack_x"},     int'(pack_x), 0);
    check({tag, "_pack_y"},     int'(pack_y), 0);
    check({tag, "_tx_data"},    int'(sif.spi_tx_data), 0);
  endtask

  typedef struct {
    logic        en;
    logic        vld;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        exp_req;
    logic [9:0]  exp_px;
    logic [8:0]  exp_py;
    logic        exp_start;
    logic [15:0] exp_tx;
    logic [3:0]  exp_drop;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, s0, p0, f0, nf, rel;

    // Applied from IDLE after the first frame: shadow holds 0x155/0x0AA, last word 0x00AA.
    vecs[0] = '{1'b0, 1'b1, 10'h3FF, 9'h1FF, 1'b0, 10'h155, 9'h0AA, 1'b0, 16'h00AA, 4'd0};
    vecs[1] = '{1'b1, 1'b0, 10'h000, 9'h000, 1'b0, 10'h155, 9'h0AA, 1'b0, 16'h00AA, 4'd0};
    vecs[2] = '{1'b1, 1'b1, 10'h2AA, 9'h155, 1'b1, 10'h2AA, 9'h155, 1'b0, 16'h00AA, 4'd0};
    vecs[3] = '{1'b1, 1'b1, 10'h0F0, 9'h00F, 1'b0, 10'h0F0, 9'h00F, 1'b0, 16'h00AA, 4'd0};
    vecs[4] = '{1'b0, 1'b1, 10'h111, 9'h111, 1'b0, 10'h0F0, 9'h00F, 1'b1, 16'h82AA, 4'd0};
    vecs[5] = '{1'b1, 1'b0, 10'h000, 9'h000, 1'b0, 10'h0F0, 9'h00F, 1'b0, 16'h82AA, 4'd0};

    // Reset state.
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("rst");

    // Single frame: pack_req one cycle after the coordinate, start issued from
    // START_X and seen two cycles after pack_req; X/Y starts 20+1+4+1 apart.
    enable = 1'b1;
    s0 = st_dat.size();
    p0 = pr_cyc.size();
    nf = n_frame;
    e0 = cyc;
    pulse_coord(10'h155, 9'h0AA);
    check("t1_pack_req", int'(pack_req), 1);
    check("t1_pack_x", int'(pack_x), 'h155);
    check("t1_pack_y", int'(pack_y), 'h0AA);
    wait_frames(nf + 1, "t1_frames");
    check("t1_start_latency", st_cyc_at(s0) - e0, 3);
    check("t1_x_word", st_dat_at(s0), 'h8155);
    check("t1_y_word", st_dat_at(s0 + 1), 'h00AA);
    check("t1_spacing", st_cyc_at(s0 + 1) - st_cyc_at(s0), 26);
    check("t1_fs_after_done", fs_cyc_at(fs_cyc.size() - 1) - done_cyc, 1);
    check("t1_pack_req_count", pr_cyc.size() - p0, 1);
    repeat (12) tick();
    check("t1_start_count", st_dat.size() - s0, 2);
    check("t1_frames_once", n_frame - nf, 1);
    check("t1_drop", int'(drop_count), 0);

    // Table: enable gating in IDLE, capture, coordinate during LATCH.
    s0 = st_dat.size();
    p0 = pr_cyc.size();
    f0 = fs_cyc.size();
    nf = n_frame;
    for (int i = 0; i < 6; i++) begin
      enable      = vecs[i].en;
      coord_valid = vecs[i].vld;
      coord_x     = vecs[i].x;
      coord_y     = vecs[i].y;
      tick();
      check($sformatf("vec%0d_pack_req", i), int'(pack_req), int'(vecs[i].exp_req));
      check($sformatf("vec%0d_pack_x", i), int'(pack_x), int'(vecs[i].exp_px));
      check($sformatf("vec%0d_pack_y", i), int'(pack_y), int'(vecs[i].exp_py));
      check($sformatf("vec%0d_spi_start", i), int'(sif.spi_start), int'(vecs[i].exp_start));
      check($sformatf("vec%0d_tx_data", i), int'(sif.spi_tx_data), int'(vecs[i].exp_tx));
      check($sformatf("vec%0d_drop", i), int'(drop_count), int'(vecs[i].exp_drop));
    end
    coord_valid = 1'b0;

    // Enable dropped mid-frame: frame finishes, ignored coord leaves no trace,
    // the pending coordinate goes out after holdoff.
    enable = 1'b0;
    tick();
    pulse_coord(10'h3C3, 9'h1C3);
    wait_frames(nf + 2, "en_frames");
    check("en_y_word", st_dat_at(s0 + 1), 'h0155);
    check("en_pend_x_word", st_dat_at(s0 + 2), 'h80F0);
    check("en_pend_y_word", st_dat_at(s0 + 3), 'h000F);
    check("en_pend_req_after_holdoff", pr_cyc_at(p0 + 1) - fs_cyc_at(f0), 10);
    check("en_drop", int'(drop_count), 0);
    repeat (12) tick();
    check("en_pack_req_count", pr_cyc.size() - p0, 2);
    enable = 1'b1;

    // Coalescing: three coordinates during WAIT_X, only the last is sent.
    s0 = st_dat.size();
    p0 = pr_cyc.size();
    f0 = fs_cyc.size();
    nf = n_frame;
    pulse_coord(10'h001, 9'h002);
    wait_starts(s0 + 1, "t3_first_start");
    pulse_coord(10'h010, 9'h011);
    tick();
    pulse_coord(10'h020, 9'h022);
    tick();
    pulse_coord(10'h3FF, 9'h1FF);
    check("t3_drop", int'(drop_count), 2);
    wait_frames(nf + 2, "t3_frames");
    check("t3_x_word", st_dat_at(s0 + 2), 'h83FF);
    check("t3_y_word", st_dat_at(s0 + 3), 'h01FF);
    check("t3_req_after_holdoff", pr_cyc_at(p0 + 1) - fs_cyc_at(f0), 10);
    repeat (12) tick();
    check("t3_pack_req_count", pr_cyc.size() - p0, 2);
    check("t3_start_count", st_dat.size() - s0, 4);

    // Busy hold: seven START_X cycles with busy high, start follows the release.
    s0 = st_dat.size();
    nf = n_frame;
    force_busy = 1'b1;
    pulse_coord(10'h100, 9'h100);
    repeat (8) tick();
    check("t2_no_start_while_busy", st_dat.size() - s0, 0);
    force_busy = 1'b0;
    rel = cyc;
    wait_frames(nf + 1, "t2_frames");
    check("t2_start_at_release", st_cyc_at(s0) - rel, 1);
    check("t2_x_word", st_dat_at(s0), 'h8100);
    check("t2_y_word", st_dat_at(s0 + 1), 'h0100);
    repeat (12) tick();
    check("t2_start_count", st_dat.size() - s0, 2);

    // Reset while waiting on the Y word, then a fresh frame.
    s0 = st_dat.size();
    nf = n_frame;
    pulse_coord(10'h055, 9'h066);
    wait_starts(s0 + 2, "t5_y_started");
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("t5");
    reset = 1'b0;
    tick();
    check("t5_no_frame_sent", n_frame - nf, 0);
    s0 = st_dat.size();
    pulse_coord(10'h0AB, 9'h0CD);
    wait_frames(nf + 1, "t5_frames");
    check("t5_x_word", st_dat_at(s0), 'h80AB);
    check("t5_y_word", st_dat_at(s0 + 1), 'h00CD);
    repeat (12) tick();

    // Saturation: 18 back-to-back coordinates during a frame, 4-bit counter.
    s0 = st_dat.size();
    nf = n_frame;
    pulse_coord(10'h001, 9'h001);
    wait_starts(s0 + 1, "t6_first_start");
    for (int i = 0; i < 18; i++) begin
      coord_valid = 1'b1;
      coord_x     = 10'(10'h200 + i);
      coord_y     = 9'(i);
      tick();
      if (i == 15) check("t6_drop_reaches_max", int'(drop_count), 'hF);
    end
    coord_valid = 1'b0;
    check("t6_drop_holds", int'(drop_count), 'hF);
    wait_frames(nf + 2, "t6_frames");
    check("t6_x_word", st_dat_at(s0 + 2), 'h8211);
    check("t6_y_word", st_dat_at(s0 + 3), 'h0011);
    repeat (12) tick();

    check("tx_data_stable", n_unstable, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
